phy_rx_deframer: RTL and testbench

Receive-side counterpart of the transmit path: accepts the 4-bit nibble stream and `phy_rx_dv` framing from the PHY and reassembles it into the byte/valid interface and 24-bit control block format that the transmit path consumes. Bytes are streamed out as they complete. At end of frame the block emits one control word carrying the byte count, or flags the frame as bad. It sits between the PHY pins and the receive buffer, entirely in the `clk_phy` domain.

---
 rtl/phy_rx_deframer.sv | 121 ++++++++++++
 tb/tb_phy_rx_deframer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deframer.sv
// Receive deframer: rebuilds bytes from the PHY nibble stream (low nibble first)
// and reports each frame's length on a control strobe, or flags a bad frame.
`timescale 1ns/1ps
module phy_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 12
) (
  input  logic         clk_phy,
  input  logic         reset,
  input  logic [3:0]   phy_data_in,
  input  logic         phy_rx_dv,
  output logic [7:0]   r_data_out,
  output logic         r_data_valid,
  output logic [23:0]  r_ctrl_out,
  output logic         r_ctrl_valid,
  output logic         r_frame_err
);

  typedef enum logic [1:0] {
    StDrain,
    StIdle,
    StHi,
    StLo
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [3:0]         r_lo;
  logic [3:0]         w_lo_d;
  logic [7:0]         w_data_d;
  logic               w_data_valid_d;
  logic [23:0]        w_ctrl_d;
  logic               w_ctrl_valid_d;
  logic               w_frame_err_d;
  logic               w_cnt_sat;
  logic               w_len_ok;

  // A saturated counter no longer reflects the true length, so it is never a good frame.
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});
  assign w_len_ok  = (r_cnt >= CNT_W'(MIN_LEN)) && (r_cnt <= CNT_W'(MAX_LEN)) && !w_cnt_sat;

  // State, datapath and registered output strobes.
  always_ff @(posedge clk_phy or posedge reset) begin
    if (reset) begin
      r_state      <= StDrain;
      r_cnt        <= '0;
      r_lo         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_ctrl_out   <= '0;
      r_ctrl_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_lo         <= w_lo_d;
      r_data_out   <= w_data_d;
      r_data_valid <= w_data_valid_d;
      r_ctrl_out   <= w_ctrl_d;
      r_ctrl_valid <= w_ctrl_valid_d;
      r_frame_err  <= w_frame_err_d;
    end
  end

  // Next-state logic and next-cycle output values.
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_lo_d         = r_lo;
    w_data_d       = r_data_out;
    w_data_valid_d = 1'b0;
    w_ctrl_d       = r_ctrl_out;
    w_ctrl_valid_d = 1'b0;
    w_frame_err_d  = 1'b0;
    unique case (r_state)
      // A frame already in flight at reset is swallowed until the line goes idle.
      StDrain: begin
        if (!phy_rx_dv) begin
          w_state_d = StIdle;
        end
      end
      StIdle: begin
        if (phy_rx_dv) begin
          w_lo_d    = phy_data_in;
          w_cnt_d   = '0;
          w_state_d = StHi;
        end
      end
      StHi: begin
        if (phy_rx_dv) begin
          w_data_d       = {phy_data_in, r_lo};
          w_data_valid_d = 1'b1;
          w_cnt_d        = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
          w_state_d      = StLo;
        end else begin
          // Frame ended on a half byte: drop it and flag the frame.
          w_frame_err_d = 1'b1;
          w_state_d     = StIdle;
        end
      end
      StLo: begin
        if (phy_rx_dv) begin
          w_lo_d    = phy_data_in;
          w_state_d = StHi;
        end else begin
          w_state_d = StIdle;
          if (w_len_ok) begin
            w_ctrl_d       = {r_cnt, r_cnt};
            w_ctrl_valid_d = 1'b1;
          end else begin
            w_frame_err_d = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer: stimulus pushes expected bytes/strobes,
// a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_phy_rx_deframer;

  typedef enum logic [1:0] {KByte, KCtrl, KErr} kind_e;
  typedef struct {
    kind_e       kind;
    logic [23:0] val;
  } exp_t;

  logic        clk_phy = 1'b0;
  logic        reset;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic [23:0] r_ctrl_out;
  logic        r_ctrl_valid;
  logic        r_frame_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic prev_dv  = 1'b0;

  phy_rx_deframer dut (
    .clk_phy      (clk_phy),
    .reset        (reset),
    .phy_data_in  (phy_data_in),
    .phy_rx_dv    (phy_rx_dv),
    .r_data_out   (r_data_out),
    .r_data_valid (r_data_valid),
    .r_ctrl_out   (r_ctrl_out),
    .r_ctrl_valid (r_ctrl_valid),
    .r_frame_err  (r_frame_err)
  );

  always #5 clk_phy = ~clk_phy;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_pop(input kind_e kind, input logic [23:0] val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_output: kind %0d value %h, expected nothing at %0t",
               kind, val, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        failures++;
        $display("FAIL scoreboard: got kind %0d value %h, expected kind %0d value %h at %0t",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Monitor: compare every presented output against the scoreboard queue.
  always @(negedge clk_phy) begin
    if (r_data_valid) chk_pop(KByte, {16'h0, r_data_out});
    if (r_ctrl_valid) chk_pop(KCtrl, r_ctrl_out);
    if (r_frame_err)  chk_pop(KErr, 24'h0);
    if (r_data_valid) begin
      checks++;
      if (prev_dv) begin
        failures++;
        $display("FAIL byte_rate: data_valid high 2 cycles, got 1 expected 0 at %0t", $time);
      end
    end
    if (r_ctrl_valid || r_frame_err) begin
      checks++;
      if ((r_ctrl_valid && r_frame_err) || r_data_valid) begin
        failures++;
        $display("FAIL strobe_overlap: ctrl %b err %b dv %b expected single strobe at %0t",
                 r_ctrl_valid, r_frame_err, r_data_valid, $time);
      end
    end
    prev_dv = r_data_valid;
  end

  // Apply one nibble; returns 1ns after the edge that samples it.
  task automatic drive(input logic dv, input logic [3:0] d);
    phy_rx_dv   = dv;
    phy_data_in = d;
    @(posedge clk_phy);
    #1;
  endtask

  function automatic logic [7:0] pat(input int n, input int i);
    logic [7:0] b;
    if (n == 64) b = (i < 4 || i >= 60) ? 8'h00 : 8'hFF;
    else         b = i[7:0] ^ 8'h5A;
    return b;
  endfunction

  task automatic frame(input int n, input bit odd);
    logic [7:0] b;
    bit         good;
    for (int i = 0; i < n; i++) begin
      b = pat(n, i);
      q.push_back('{kind: KByte, val: {16'h0, b}});
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
      if (i == 0 || i == n - 1) check("byte_latency", {23'h0, r_data_valid}, 24'h1);
    end
    if (odd) drive(1'b1, 4'hA);
    good = !odd && n >= 64 && n <= 1518;
    if (good) q.push_back('{kind: KCtrl, val: {n[11:0], n[11:0]}});
    else      q.push_back('{kind: KErr, val: 24'h0});
    drive(1'b0, 4'h0);
    if (good) check("ctrl_latency", {23'h0, r_ctrl_valid}, 24'h1);
    else      check("err_latency", {23'h0, r_frame_err}, 24'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},       {16'h0, r_data_out},   24'h0);
    check({tag, "_data_valid"}, {23'h0, r_data_valid}, 24'h0);
    check({tag, "_ctrl"},       r_ctrl_out,            24'h0);
    check({tag, "_ctrl_valid"}, {23'h0, r_ctrl_valid}, 24'h0);
    check({tag, "_frame_err"},  {23'h0, r_frame_err},  24'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    reset       = 1'b0;
    phy_rx_dv   = 1'b0;
    phy_data_in = 4'h0;
    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk_phy);
    #1 reset = 1'b0;
    drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);

    frame(64, 1'b0);
    frame(64, 1'b1);
    frame(63, 1'b0);
    check("ctrl_hold_short", r_ctrl_out, 24'h040040);
    frame(1519, 1'b0);
    check("ctrl_hold_long", r_ctrl_out, 24'h040040);
    frame(1518, 1'b0);
    check("ctrl_max", r_ctrl_out, 24'h5EE5EE);

    // Back-to-back: each frame ends with exactly one dv-low cycle.
    frame(64, 1'b0);
    frame(64, 1'b0);

    // Reset in the middle of byte 20 with dv held high.
    for (int i = 0; i < 20; i++) begin
      b = pat(64, i);
      q.push_back('{kind: KByte, val: {16'h0, b}});
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
    end
    b = pat(64, 20);
    drive(1'b1, b[3:0]);
    reset = 1'b1;
    #1 check_all_zero("midreset");
    drive(1'b1, b[7:4]);
    check_all_zero("midreset_hold");
    reset = 1'b0;
    for (int i = 21; i < 64; i++) begin
      b = pat(64, i);
      drive(1'b1, b[3:0]);
      drive(1'b1, b[7:4]);
    end
    drive(1'b0, 4'h0);
    check("drain_no_ctrl", {23'h0, r_ctrl_valid}, 24'h0);
    check("drain_no_err", {23'h0, r_frame_err}, 24'h0);
    frame(64, 1'b0);

    repeat (4) drive(1'b0, 4'h0);
    check("scoreboard_empty", 24'(q.size()), 24'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
